// File: rtl/snn_pkg.sv
`default_nettype none
// ============================================================================
// Package     : snn_pkg
// Description : Shared types and helpers for the spiking-neuron datapath
//               (synaptic current width, spike vector, saturating add).
// Revision    : 1.0 - initial release
// ============================================================================
package snn_pkg;

    localparam int ISYN_W        = 8;
    localparam int SPIKE_VEC_MAX = 8;
    localparam int SUM_W_MAX     = 16;

    typedef logic [ISYN_W-1:0]        isyn_t;
    typedef logic [SPIKE_VEC_MAX-1:0] spike_vec_t;

    typedef struct packed {
        isyn_t value;
        logic  clipped;
    } sat_res_t;

    // Unsigned add of a current and a non-negative weight sum, clipped to isyn_t.
    function automatic sat_res_t sat_add_u(input isyn_t a, input logic [SUM_W_MAX-1:0] b);
        logic [SUM_W_MAX:0] total;
        sat_res_t           r;
        total = {{(SUM_W_MAX+1-ISYN_W){1'b0}}, a} + {1'b0, b};
        if (total > {{(SUM_W_MAX+1-ISYN_W){1'b0}}, {ISYN_W{1'b1}}}) begin
            r.value   = '1;
            r.clipped = 1'b1;
        end else begin
            r.value   = total[ISYN_W-1:0];
            r.clipped = 1'b0;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/synapse_integrator_if.sv
`default_nettype none
// ============================================================================
// Interface   : synapse_integrator_if
// Description : Weight-write handshake bus (valid/ready, index, value).
// Revision    : 1.0 - initial release
// ============================================================================
interface synapse_integrator_if #(
    parameter int N_IN    = 4,
    parameter int W_WIDTH = 8
);
    logic                    wr_valid;
    logic                    wr_ready;
    logic [$clog2(N_IN)-1:0] wr_addr;
    logic [W_WIDTH-1:0]      wr_data;

    modport master (output wr_valid, output wr_addr, output wr_data, input  wr_ready);
    modport slave  (input  wr_valid, input  wr_addr, input  wr_data, output wr_ready);
endinterface
`default_nettype wire

// File: rtl/spike_weight_sum.sv
`default_nettype none
// ============================================================================
// Module      : spike_weight_sum
// Description : Weight bank with write handshake and a combinational sum of
//               the weights selected by spike_in. SYN_INHIBIT_EN makes the
//               weights signed (sign-extended into the sum).
// Revision    : 1.0 - initial release
// ============================================================================
module spike_weight_sum
    import snn_pkg::*;
#(
    parameter int N_IN    = 4,
    parameter int W_WIDTH = 8,
    parameter int SUM_W   = W_WIDTH + $clog2(N_IN) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_IN-1:0]      spike_in,
    synapse_integrator_if.slave  wr,
    output logic [SUM_W-1:0]     sum
);

    logic [W_WIDTH-1:0] weight_q [N_IN];
    logic [W_WIDTH-1:0] weight_d [N_IN];
    logic               wr_ready_q;
    logic               wr_ready_d;
    logic               accept;

    assign wr.wr_ready = wr_ready_q;

    // The cycle after an accept is the commit slot, so ready drops for one cycle.
    always_comb begin
        accept     = wr.wr_valid && wr_ready_q;
        wr_ready_d = !accept;
        weight_d   = weight_q;
        if (accept) begin
            weight_d[wr.wr_addr] = wr.wr_data;
        end
    end

    // Reads the registered bank, so a same-cycle write is seen one cycle later.
    always_comb begin
        sum = '0;
        for (int k = 0; k < N_IN; k++) begin
            if (spike_in[k]) begin
`ifdef SYN_INHIBIT_EN
                sum = sum + {{(SUM_W-W_WIDTH){weight_q[k][W_WIDTH-1]}}, weight_q[k]};
`else
                sum = sum + {{(SUM_W-W_WIDTH){1'b0}}, weight_q[k]};
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ready_q <= 1'b1;
            for (int k = 0; k < N_IN; k++) begin
                weight_q[k] <= '0;
            end
        end else begin
            wr_ready_q <= wr_ready_d;
            for (int k = 0; k < N_IN; k++) begin
                weight_q[k] <= weight_d[k];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/synapse_integrator.sv
`default_nettype none
// ============================================================================
// Module      : synapse_integrator
// Description : Accumulates spike-weighted synaptic current with prescaled
//               exponential decay and saturation; feeds a LIF neuron's Isyn.
//               Optional macro SYN_INHIBIT_EN: signed (inhibitory) weights
//               with clamping at zero as well as at full scale.
// Revision    : 1.0 - initial release
// ============================================================================
module synapse_integrator
    import snn_pkg::*;
#(
    parameter int N_IN         = 4,
    parameter int W_WIDTH      = 8,
    parameter int I_WIDTH      = ISYN_W,
    parameter int DECAY_SHIFT  = 2,
    parameter int DECAY_PERIOD = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic [N_IN-1:0]      spike_in,
    synapse_integrator_if.slave  wr,
    output logic [I_WIDTH-1:0]   isyn,
    output logic                 sat
);

    localparam int               SUM_W    = W_WIDTH + $clog2(N_IN) + 1;
    localparam int               CNT_W    = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECAY_PERIOD - 1);

    logic [SUM_W-1:0]   spike_sum;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [I_WIDTH-1:0] isyn_q, isyn_d;
    logic [I_WIDTH-1:0] base;
    logic               sat_q, sat_d;
    logic               decay_tick;

`ifdef SYN_INHIBIT_EN
    localparam int TOT_W = ((I_WIDTH + 1 > SUM_W) ? I_WIDTH + 1 : SUM_W) + 1;
    localparam logic signed [TOT_W-1:0] I_MAX = $signed({{(TOT_W-I_WIDTH){1'b0}}, {I_WIDTH{1'b1}}});
    logic signed [TOT_W-1:0] total;
`else
    sat_res_t res;
`endif

    spike_weight_sum #(
        .N_IN    (N_IN),
        .W_WIDTH (W_WIDTH),
        .SUM_W   (SUM_W)
    ) u_spike_weight_sum (
        .clk      (clk),
        .rst_n    (rst_n),
        .spike_in (spike_in),
        .wr       (wr),
        .sum      (spike_sum)
    );

    always_comb begin
        decay_tick = ena && (cnt_q == CNT_LAST);
        // Small values shift to zero and therefore never decay below themselves.
        base   = decay_tick ? (isyn_q - (isyn_q >> DECAY_SHIFT)) : isyn_q;
        cnt_d  = cnt_q;
        isyn_d = isyn_q;
        sat_d  = sat_q;
`ifdef SYN_INHIBIT_EN
        total = $signed({{(TOT_W-I_WIDTH){1'b0}}, base})
              + $signed({{(TOT_W-SUM_W){spike_sum[SUM_W-1]}}, spike_sum});
`else
        res = sat_add_u(isyn_t'(base), {{(SUM_W_MAX-SUM_W){1'b0}}, spike_sum});
`endif
        if (ena) begin
            cnt_d = decay_tick ? '0 : cnt_q + 1'b1;
`ifdef SYN_INHIBIT_EN
            if (total < 0) begin
                isyn_d = '0;
                sat_d  = 1'b1;
            end else if (total > I_MAX) begin
                isyn_d = '1;
                sat_d  = 1'b1;
            end else begin
                isyn_d = total[I_WIDTH-1:0];
                sat_d  = 1'b0;
            end
`else
            isyn_d = I_WIDTH'(res.value);
            sat_d  = res.clipped;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            isyn_q <= '0;
            sat_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            isyn_q <= isyn_d;
            sat_q  <= sat_d;
        end
    end

    assign isyn = isyn_q;
    assign sat  = sat_q;

endmodule
`default_nettype wire
